// File: rtl/obstacle_detector_if.sv
// Distance-in / average-and-flag-out bundle between the reader consumer and its host.
// The slave side is the obstacle detector; the master side drives the raw distance word.
interface obstacle_detector_if #(
    parameter int N_WIDTH = 17
);
    logic [N_WIDTH-1:0] OBSTACLE_DETECTOR_DISTANCE_InBus;
    logic [N_WIDTH-1:0] OBSTACLE_DETECTOR_AVG_OutBus;
    logic               OBSTACLE_DETECTOR_AVG_VALID_Out;
    logic               OBSTACLE_DETECTOR_OBSTACLE_Out;
    logic               OBSTACLE_DETECTOR_TIMEOUT_Out;

    modport master (
        output OBSTACLE_DETECTOR_DISTANCE_InBus,
        input  OBSTACLE_DETECTOR_AVG_OutBus,
        input  OBSTACLE_DETECTOR_AVG_VALID_Out,
        input  OBSTACLE_DETECTOR_OBSTACLE_Out,
        input  OBSTACLE_DETECTOR_TIMEOUT_Out
    );

    modport slave (
        input  OBSTACLE_DETECTOR_DISTANCE_InBus,
        output OBSTACLE_DETECTOR_AVG_OutBus,
        output OBSTACLE_DETECTOR_AVG_VALID_Out,
        output OBSTACLE_DETECTOR_OBSTACLE_Out,
        output OBSTACLE_DETECTOR_TIMEOUT_Out
    );
endinterface

// File: rtl/obstacle_detector.sv
// Captures each completed HC-SR04 echo count on its falling edge, keeps a 4-sample moving average
// and drives a debounced, hysteretic obstacle flag; a silent sensor is treated as max distance.
module obstacle_detector #(
    parameter int                 N_WIDTH        = 17,
    parameter int                 Q_WIDTH        = 8,
    parameter logic [N_WIDTH-1:0] NEAR_THRESH    = 17'd5120,
    parameter logic [N_WIDTH-1:0] FAR_THRESH     = 17'd6400,
    parameter int                 CONFIRM        = 3,
    parameter int                 TIMEOUT_CYCLES = 600000
) (
    input  logic                OBSTACLE_DETECTOR_CLOCK_50,
    input  logic                OBSTACLE_DETECTOR_RESET_InHigh,
    obstacle_detector_if.slave  bus
);
    localparam int                 TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         CONFIRM_W    = 4'(CONFIRM);
    localparam logic [N_WIDTH-1:0] ALL_ONES     = {N_WIDTH{1'b1}};
    localparam logic [N_WIDTH-1:0] ZERO         = {N_WIDTH{1'b0}};

    if ((Q_WIDTH > N_WIDTH) || (NEAR_THRESH >= FAR_THRESH) || (CONFIRM < 1) || (CONFIRM > 15)) begin : g_bad_params
        $error("obstacle_detector: inconsistent parameters");
    end

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_ARMING    = 2'd1,
        ST_OBSTACLE  = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    logic               clk;
    logic               rst;
    logic [N_WIDTH-1:0] dist_s;

    logic [N_WIDTH-1:0] prev_r;
    logic [N_WIDTH-1:0] smp0_r, smp1_r, smp2_r, smp3_r;
    logic [2:0]         fill_r;
    logic [TW-1:0]      tmo_cnt_r;
    logic               push_d_r;
    logic [N_WIDTH-1:0] avg_r;
    logic               avg_valid_r;
    logic               timeout_r;
    logic               obstacle_r;
    state_t             state_r, state_s;
    logic [3:0]         confirm_r, confirm_s;

    logic               drop_s, tmo_s, push_s;
    logic [N_WIDTH-1:0] sample_s;
    logic [N_WIDTH+1:0] sum_s;
    logic               near_s, far_s, obstacle_s;

    assign clk    = OBSTACLE_DETECTOR_CLOCK_50;
    assign rst    = OBSTACLE_DETECTOR_RESET_InHigh;
    assign dist_s = bus.OBSTACLE_DETECTOR_DISTANCE_InBus;

    assign bus.OBSTACLE_DETECTOR_AVG_OutBus    = avg_r;
    assign bus.OBSTACLE_DETECTOR_AVG_VALID_Out = avg_valid_r;
    assign bus.OBSTACLE_DETECTOR_OBSTACLE_Out  = obstacle_r;
    assign bus.OBSTACLE_DETECTOR_TIMEOUT_Out   = timeout_r;

    // Measurement-end detection, timeout injection and 4-sample sum; a real drop beats a same-cycle timeout.
    always_comb begin
        drop_s   = (dist_s < prev_r) && (prev_r != ZERO);
        tmo_s    = !drop_s && (tmo_cnt_r == TIMEOUT_LAST);
        push_s   = drop_s || tmo_s;
        sample_s = drop_s ? prev_r : ALL_ONES;
        sum_s    = {2'b00, smp0_r} + {2'b00, smp1_r} + {2'b00, smp2_r} + {2'b00, smp3_r};
    end

    // Sample capture: previous-value tracking, shift register, fill level and silence timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r    <= ZERO;
            smp0_r    <= ZERO;
            smp1_r    <= ZERO;
            smp2_r    <= ZERO;
            smp3_r    <= ZERO;
            fill_r    <= 3'd0;
            tmo_cnt_r <= {TW{1'b0}};
            push_d_r  <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            prev_r   <= dist_s;
            push_d_r <= push_s;
            if (push_s) begin
                smp0_r    <= sample_s;
                smp1_r    <= smp0_r;
                smp2_r    <= smp1_r;
                smp3_r    <= smp2_r;
                fill_r    <= (fill_r == 3'd4) ? 3'd4 : fill_r + 3'd1;
                tmo_cnt_r <= {TW{1'b0}};
                timeout_r <= tmo_s;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Moving average register, refreshed one edge after every push; valid only once the window is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            avg_r       <= ZERO;
            avg_valid_r <= 1'b0;
        end else begin
            avg_valid_r <= push_d_r && (fill_r == 3'd4);
            if (push_d_r) begin
                avg_r <= sum_s[N_WIDTH+1:2];
            end
        end
    end

    // Hysteresis/debounce next-state logic; equality with either threshold never qualifies.
    always_comb begin
        state_s    = state_r;
        confirm_s  = confirm_r;
        near_s     = (avg_r < NEAR_THRESH);
        far_s      = (avg_r > FAR_THRESH);
        if (avg_valid_r) begin
            case (state_r)
                ST_CLEAR: begin
                    if (near_s) begin
                        confirm_s = 4'd1;
                        state_s   = (CONFIRM_W == 4'd1) ? ST_OBSTACLE : ST_ARMING;
                    end else begin
                        confirm_s = 4'd0;
                    end
                end
                ST_ARMING: begin
                    if (near_s) begin
                        if ((confirm_r + 4'd1) == CONFIRM_W) begin
                            state_s   = ST_OBSTACLE;
                            confirm_s = 4'd0;
                        end else begin
                            confirm_s = confirm_r + 4'd1;
                        end
                    end else begin
                        state_s   = ST_CLEAR;
                        confirm_s = 4'd0;
                    end
                end
                ST_OBSTACLE: begin
                    if (far_s) begin
                        confirm_s = 4'd1;
                        state_s   = (CONFIRM_W == 4'd1) ? ST_CLEAR : ST_RELEASING;
                    end else begin
                        confirm_s = 4'd0;
                    end
                end
                ST_RELEASING: begin
                    if (far_s) begin
                        if ((confirm_r + 4'd1) == CONFIRM_W) begin
                            state_s   = ST_CLEAR;
                            confirm_s = 4'd0;
                        end else begin
                            confirm_s = confirm_r + 4'd1;
                        end
                    end else begin
                        state_s   = ST_OBSTACLE;
                        confirm_s = 4'd0;
                    end
                end
                default: begin
                    state_s   = ST_CLEAR;
                    confirm_s = 4'd0;
                end
            endcase
        end else begin
            state_s   = state_r;
            confirm_s = confirm_r;
        end
        obstacle_s = (state_s == ST_OBSTACLE) || (state_s == ST_RELEASING);
    end

    // State, confirm count and flag registers; the flag is registered from the next state so it moves with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_CLEAR;
            confirm_r  <= 4'd0;
            obstacle_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            confirm_r  <= confirm_s;
            obstacle_r <= obstacle_s;
        end
    end
endmodule

// File: tb/tb_obstacle_detector.sv
// Directed bench for obstacle_detector: fill, debounce/hysteresis, timeout injection,
// drop-versus-timeout priority and reset out of ARMING. Timeout shortened to 64 cycles.
module tb_obstacle_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    obstacle_detector_if #(.N_WIDTH(17)) bus_if ();

    obstacle_detector #(
        .N_WIDTH       (17),
        .Q_WIDTH       (8),
        .NEAR_THRESH   (17'd5120),
        .FAR_THRESH    (17'd6400),
        .CONFIRM       (3),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .OBSTACLE_DETECTOR_CLOCK_50    (clk),
        .OBSTACLE_DETECTOR_RESET_InHigh(rst),
        .bus                           (bus_if.slave)
    );

    wire [16:0] avg_w   = bus_if.OBSTACLE_DETECTOR_AVG_OutBus;
    wire        valid_w = bus_if.OBSTACLE_DETECTOR_AVG_VALID_Out;
    wire        obst_w  = bus_if.OBSTACLE_DETECTOR_OBSTACLE_Out;
    wire        tmo_w   = bus_if.OBSTACLE_DETECTOR_TIMEOUT_Out;

    always #10 clk = ~clk;

    // One echo: short ramp to v then back to 0; returns at the negedge after the average edge.
    task automatic capture(input logic [16:0] v);
        @(negedge clk) bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = v >> 1;
        @(negedge clk) bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = v;
        @(negedge clk) bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = 17'd0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = 17'd0;
        @(negedge clk) bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = 17'h00800;
        @(negedge clk) bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = 17'h00400;
        @(negedge clk);
        checks++; if (avg_w !== 17'd0) begin errors++; $display("FAIL reset_avg: got %0h expected 0", avg_w); end
        checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid_w); end
        checks++; if (obst_w !== 1'b0) begin errors++; $display("FAIL reset_obstacle: got %0b expected 0", obst_w); end
        checks++; if (tmo_w !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", tmo_w); end
        bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = 17'd0;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            capture(17'h01000);
            checks++;
            if (valid_w !== (i == 3)) begin
                errors++; $display("FAIL fill_valid[%0d]: got %0b expected %0b", i, valid_w, (i == 3));
            end
        end
        checks++; if (avg_w !== 17'h01000) begin errors++; $display("FAIL fill_avg: got %0h expected 1000", avg_w); end
        @(negedge clk);
        checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL fill_pulse_width: got %0b expected 0", valid_w); end
        checks++; if (obst_w !== 1'b0) begin errors++; $display("FAIL fill_obstacle: got %0b expected 0", obst_w); end
    endtask

    task automatic test_obstacle();
        logic exp_e1 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_e2 [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            capture(17'h01000);
            checks++;
            if (obst_w !== exp_e1[i]) begin
                errors++; $display("FAIL obst_at_avg[%0d]: got %0b expected %0b", i, obst_w, exp_e1[i]);
            end
            @(negedge clk);
            checks++;
            if (obst_w !== exp_e2[i]) begin
                errors++; $display("FAIL obst_after_avg[%0d]: got %0b expected %0b", i, obst_w, exp_e2[i]);
            end
        end
    endtask

    task automatic test_release();
        logic [16:0] smp [7]  = '{17'h03800, 17'h00C00, 17'h01400, 17'h00800, 17'h08000, 17'h08000, 17'h08000};
        logic [16:0] avg [7]  = '{17'h01A00, 17'h01900, 17'h01A00, 17'h01800, 17'h02A00, 17'h04700, 17'h06200};
        logic        flag [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            capture(smp[i]);
            checks++;
            if (avg_w !== avg[i] || valid_w !== 1'b1) begin
                errors++; $display("FAIL release_avg[%0d]: got %0h/%0b expected %0h/1", i, avg_w, valid_w, avg[i]);
            end
            @(negedge clk);
            checks++;
            if (obst_w !== flag[i]) begin
                errors++; $display("FAIL release_flag[%0d]: got %0b expected %0b", i, obst_w, flag[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc [4] = '{0, 0, 0, 0};
        int pulses = 0;
        for (int k = 1; k <= 400 && pulses < 4; k++) begin
            @(negedge clk);
            if (valid_w === 1'b1) begin
                cyc[pulses] = k;
                pulses++;
            end
        end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL timeout_pulses: got %0d expected 4", pulses); end
        checks++; if (cyc[0] !== 63) begin errors++; $display("FAIL timeout_first: got %0d expected 63", cyc[0]); end
        checks++; if (cyc[3] - cyc[2] !== 64) begin errors++; $display("FAIL timeout_period: got %0d expected 64", cyc[3] - cyc[2]); end
        checks++; if (avg_w !== 17'h1FFFF) begin errors++; $display("FAIL timeout_avg: got %0h expected 1ffff", avg_w); end
        checks++; if (tmo_w !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %0b expected 1", tmo_w); end
        checks++; if (obst_w !== 1'b0) begin errors++; $display("FAIL timeout_obstacle: got %0b expected 0", obst_w); end
    endtask

    // Starts one negedge after the last timeout's average edge; the drop lands on the next timeout edge.
    task automatic test_drop_vs_timeout();
        repeat (61) @(negedge clk);
        bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = 17'h01000;
        @(negedge clk) bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = 17'd0;
        @(negedge clk);
        checks++; if (tmo_w !== 1'b0) begin errors++; $display("FAIL race_timeout_e0: got %0b expected 0", tmo_w); end
        checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL race_valid_e0: got %0b expected 0", valid_w); end
        @(negedge clk);
        checks++; if (valid_w !== 1'b1) begin errors++; $display("FAIL race_valid_e1: got %0b expected 1", valid_w); end
        checks++; if (avg_w !== 17'h183FF) begin errors++; $display("FAIL race_avg: got %0h expected 183ff", avg_w); end
        checks++; if (tmo_w !== 1'b0) begin errors++; $display("FAIL race_timeout_e1: got %0b expected 0", tmo_w); end
    endtask

    task automatic test_reset_mid_arming();
        repeat (4) capture(17'h01000);
        checks++; if (avg_w !== 17'h01000) begin errors++; $display("FAIL arm_avg: got %0h expected 1000", avg_w); end
        @(negedge clk);
        checks++; if (obst_w !== 1'b0) begin errors++; $display("FAIL arm_obstacle: got %0b expected 0", obst_w); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (avg_w !== 17'd0) begin errors++; $display("FAIL rearm_avg_cleared: got %0h expected 0", avg_w); end
        for (int i = 0; i < 4; i++) begin
            capture(17'h01000);
            checks++;
            if (valid_w !== (i == 3)) begin
                errors++; $display("FAIL rearm_valid[%0d]: got %0b expected %0b", i, valid_w, (i == 3));
            end
        end
        @(negedge clk);
        checks++; if (obst_w !== 1'b0) begin errors++; $display("FAIL rearm_obstacle: got %0b expected 0", obst_w); end
    endtask

    initial begin
        bus_if.OBSTACLE_DETECTOR_DISTANCE_InBus = 17'd0;
        test_reset();
        test_fill();
        test_obstacle();
        test_release();
        test_timeout();
        test_drop_vs_timeout();
        test_reset_mid_arming();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
